// File: rtl/asc_pkg.sv
// Shared types and constants for the scripted four-floor elevator demo.
package asc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        DOORS  = 2'd2
    } state_t;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    localparam int N_FLOORS = 4;

    // Request script 2, 3, 0, 1 packed with entry 0 in the low bits.
    localparam logic [7:0] SCRIPT = {2'd1, 2'd0, 2'd3, 2'd2};

    function automatic logic [1:0] script_target(input logic [1:0] idx);
        return SCRIPT[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/clk_divider.sv
// Divides clk into a 50 % duty clk_nuevo and flags the clk edge on which it rises.
module clk_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk_nuevo,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_div_cnt;
    logic          r_clk_nuevo;
    logic          w_wrap;

    assign w_wrap = (r_div_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_cnt   <= '0;
            r_clk_nuevo <= 1'b0;
        end else if (w_wrap) begin
            r_div_cnt   <= '0;
            r_clk_nuevo <= ~r_clk_nuevo;
        end else begin
            r_div_cnt   <= r_div_cnt + 1'b1;
        end
    end

    assign clk_nuevo = r_clk_nuevo;
    assign tick      = w_wrap & ~r_clk_nuevo;

endmodule

// File: rtl/prueba_2_ascensor.sv
// Self-running elevator demo: walks a fixed request script one slow tick at a time.
module prueba_2_ascensor
    import asc_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int DOOR_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] piso,
    output logic [1:0] direccion,
    output logic       puertas_abiertas,
    output logic       state_andando,
    output logic       clk_nuevo
);

    localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
    localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_TICKS - 1);
    localparam logic [1:0]    TOP_FLOOR = 2'(N_FLOORS - 1);

    logic w_tick;

    clk_divider #(.CLK_DIV(CLK_DIV)) u_clk_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_nuevo (clk_nuevo),
        .tick      (w_tick)
    );

    state_t        r_state,    w_state_nx;
    logic [1:0]    r_piso,     w_piso_nx;
    logic [1:0]    r_dir,      w_dir_nx;
    logic          r_doors,    w_doors_nx;
    logic          r_andando,  w_andando_nx;
    logic [1:0]    r_req_idx,  w_req_idx_nx;
    logic [1:0]    r_target,   w_target_nx;
    logic [DW-1:0] r_door_cnt, w_door_cnt_nx;
    logic [1:0]    w_req;
    logic [1:0]    w_piso_step;

    assign w_req = script_target(r_req_idx);

    // Saturate at the shaft ends so the floor can never wrap.
    always_comb begin
        w_piso_step = r_piso;
        if (r_dir == DIR_UP && r_piso != TOP_FLOOR) begin
            w_piso_step = r_piso + 2'd1;
        end else if (r_dir == DIR_DOWN && r_piso != 2'd0) begin
            w_piso_step = r_piso - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_piso     <= 2'd0;
            r_dir      <= DIR_STOP;
            r_doors    <= 1'b0;
            r_andando  <= 1'b0;
            r_req_idx  <= 2'd0;
            r_target   <= 2'd0;
            r_door_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_piso     <= w_piso_nx;
            r_dir      <= w_dir_nx;
            r_doors    <= w_doors_nx;
            r_andando  <= w_andando_nx;
            r_req_idx  <= w_req_idx_nx;
            r_target   <= w_target_nx;
            r_door_cnt <= w_door_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_piso_nx     = r_piso;
        w_dir_nx      = r_dir;
        w_doors_nx    = r_doors;
        w_andando_nx  = r_andando;
        w_req_idx_nx  = r_req_idx;
        w_target_nx   = r_target;
        w_door_cnt_nx = r_door_cnt;

        if (w_tick) begin
            unique case (r_state)
                IDLE: begin
                    w_target_nx  = w_req;
                    w_req_idx_nx = r_req_idx + 2'd1;
                    if (w_req == r_piso) begin
                        w_state_nx    = DOORS;
                        w_doors_nx    = 1'b1;
                        w_door_cnt_nx = DOOR_LAST;
                    end else begin
                        w_state_nx   = MOVING;
                        w_andando_nx = 1'b1;
                        w_dir_nx     = (w_req > r_piso) ? DIR_UP : DIR_DOWN;
                    end
                end
                MOVING: begin
                    w_piso_nx = w_piso_step;
                    if (w_piso_step == r_target) begin
                        w_state_nx    = DOORS;
                        w_dir_nx      = DIR_STOP;
                        w_andando_nx  = 1'b0;
                        w_doors_nx    = 1'b1;
                        w_door_cnt_nx = DOOR_LAST;
                    end
                end
                DOORS: begin
                    if (r_door_cnt == '0) begin
                        w_state_nx = IDLE;
                        w_doors_nx = 1'b0;
                    end else begin
                        w_door_cnt_nx = r_door_cnt - 1'b1;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    assign piso             = r_piso;
    assign direccion        = r_dir;
    assign puertas_abiertas = r_doors;
    assign state_andando    = r_andando;

endmodule

// File: tb/tb_prueba_2_ascensor.sv
// Scoreboard bench: expected tick snapshots are queued, a monitor pops one on each clk_nuevo rise.
module tb_prueba_2_ascensor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;

    logic [1:0] piso, direccion;
    logic       puertas_abiertas, state_andando, clk_nuevo;
    logic [1:0] piso2, direccion2;
    logic       puertas2, andando2, clk_nuevo2;

    always #5 clk = ~clk;

    prueba_2_ascensor #(.CLK_DIV(2), .DOOR_TICKS(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .piso             (piso),
        .direccion        (direccion),
        .puertas_abiertas (puertas_abiertas),
        .state_andando    (state_andando),
        .clk_nuevo        (clk_nuevo)
    );

    prueba_2_ascensor #(.CLK_DIV(1), .DOOR_TICKS(1)) dut_fast (
        .clk              (clk),
        .rst_n            (rst2_n),
        .piso             (piso2),
        .direccion        (direccion2),
        .puertas_abiertas (puertas2),
        .state_andando    (andando2),
        .clk_nuevo        (clk_nuevo2)
    );

    typedef struct {
        int         edge_n;
        logic [1:0] piso;
        logic [1:0] dir;
        logic       doors;
        logic       mov;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int e, input int p, input int d, input int o, input int m);
        exp_t x;
        x.edge_n = e;
        x.piso   = 2'(p);
        x.dir    = 2'(d);
        x.doors  = o[0];
        x.mov    = m[0];
        sb.push_back(x);
    endtask

    // Edge counters since the last release of each reset.
    int ecyc = 0, ecyc2 = 0;
    bit rst_edge = 1'b1, rst2_edge = 1'b1;
    always @(posedge clk) begin
        rst_edge  = !rst_n;
        rst2_edge = !rst2_n;
        if (!rst_n)  ecyc = 0;  else ecyc++;
        if (!rst2_n) ecyc2 = 0; else ecyc2++;
    end

    logic [5:0] prev_out;
    logic       prev_cn = 1'b0;
    int         last_rise = 0;
    bit         rise_valid = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_edge) begin
            prev_out   = {piso, direccion, puertas_abiertas, state_andando};
            prev_cn    = clk_nuevo;
            rise_valid = 1'b0;
        end else begin
            if (clk_nuevo && !prev_cn) begin
                if (rise_valid) chk("period", ecyc - last_rise, 4);
                last_rise  = ecyc;
                rise_valid = 1'b1;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("tick_edge", ecyc, e.edge_n);
                    chk("piso", int'(piso), int'(e.piso));
                    chk("direccion", int'(direccion), int'(e.dir));
                    chk("puertas", int'(puertas_abiertas), int'(e.doors));
                    chk("andando", int'(state_andando), int'(e.mov));
                end
            end else begin
                chk("stable_between_ticks",
                    int'({piso, direccion, puertas_abiertas, state_andando}), int'(prev_out));
            end
            chk("inv_doors_and_moving", int'(puertas_abiertas && state_andando), 0);
            chk("inv_dir_11", int'(direccion == 2'b11), 0);
            chk("inv_stopped_dir", int'(!state_andando && direccion != 2'b00), 0);
            prev_out = {piso, direccion, puertas_abiertas, state_andando};
            prev_cn  = clk_nuevo;
        end
    end

    logic prev_cn2 = 1'b0;
    int   last_rise2 = 0;
    bit   rise2_valid = 1'b0;

    always @(negedge clk) begin
        if (rst2_edge) begin
            prev_cn2    = clk_nuevo2;
            rise2_valid = 1'b0;
        end else begin
            if (clk_nuevo2 && !prev_cn2) begin
                if (rise2_valid) chk("period_fast", ecyc2 - last_rise2, 2);
                last_rise2  = ecyc2;
                rise2_valid = 1'b1;
            end
            chk("fast_inv_doors_and_moving", int'(puertas2 && andando2), 0);
            chk("fast_inv_dir_11", int'(direccion2 == 2'b11), 0);
            chk("fast_inv_stopped_dir", int'(!andando2 && direccion2 != 2'b00), 0);
            case (ecyc2)
                1:  chk("fast_e1", int'({piso2, direccion2, puertas2, andando2}), 6'b00_01_01);
                5:  chk("fast_e5", int'({piso2, direccion2, puertas2, andando2}), 6'b10_00_10);
                7:  chk("fast_e7", int'({piso2, direccion2, puertas2, andando2}), 6'b10_00_00);
                9:  chk("fast_e9", int'({piso2, direccion2, puertas2, andando2}), 6'b10_01_01);
                11: chk("fast_e11", int'({piso2, direccion2, puertas2, andando2}), 6'b11_00_10);
                default: ;
            endcase
            prev_cn2 = clk_nuevo2;
        end
    end

    task automatic wait_empty(input int budget, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        // edge, piso, dir, doors, moving
        push( 2, 0, 1, 0, 1); push( 6, 1, 1, 0, 1); push(10, 2, 0, 1, 0);
        push(14, 2, 0, 1, 0); push(18, 2, 0, 0, 0); push(22, 2, 1, 0, 1);
        push(26, 3, 0, 1, 0); push(30, 3, 0, 1, 0); push(34, 3, 0, 0, 0);
        push(38, 3, 2, 0, 1); push(42, 2, 2, 0, 1); push(46, 1, 2, 0, 1);
        push(50, 0, 0, 1, 0); push(54, 0, 0, 1, 0); push(58, 0, 0, 0, 0);
        push(62, 0, 1, 0, 1); push(66, 1, 0, 1, 0); push(70, 1, 0, 1, 0);
        push(74, 1, 0, 0, 0); push(78, 1, 1, 0, 1);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        @(negedge clk);
        chk("edge1_all_zero",
            int'({piso, direccion, puertas_abiertas, state_andando, clk_nuevo}), 0);
        wait_empty(200, "script");

        chk("moving_before_reset", int'(state_andando), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_all_zero",
            int'({piso, direccion, puertas_abiertas, state_andando, clk_nuevo}), 0);
        push( 2, 0, 1, 0, 1); push( 6, 1, 1, 0, 1); push(10, 2, 0, 1, 0);
        rst_n = 1'b1;
        wait_empty(40, "restart");

        repeat (900) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
